shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
Parametrised sequential shift/rotate unit: the clocked successor to the 4-bit combinational shift block. It accepts a WIDTH-bit operand, a mode and a shift amount, then shifts one bit position per clock. It signals completion with a start/busy/done handshake and exposes the last bit shifted out. It sits beside the datapath as a small-area alternative to a barrel shifter.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
AW, 3, width of shift-amount port; amounts 0..2^AW-1 are legal, including amounts >= WIDTH

Ports:
clk    input   1      system clock, rising-edge
rst    input   1      reset, asynchronous, active-high
start  input   1      request; sampled only in IDLE
mode   input   3      operation select, captured with start
amt    input   AW     shift count, captured with start
din    input   WIDTH  operand, captured with start
sin    input   1      serial fill bit for modes 101/110, sampled live every SHIFT cycle
dout   output  WIDTH  result register
sout   output  1      last bit shifted/rotated out
busy   output  1      high in SHIFT and DONE states
done   output  1      one-cycle completion pulse

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high.
- Reset values: state=IDLE, dout=0, sout=0, cnt=0, busy=0, done=0. Reset asserted mid-operation aborts immediately; the partial result is discarded.
- States: IDLE, SHIFT, DONE. busy=(state!=IDLE); done=(state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE, start=1 at edge k: dout<=din, cnt<=amt, mode latched. Next state is SHIFT if amt!=0, otherwise DONE.
- SHIFT: each edge applies one 1-bit step to dout and sets sout to the bit leaving. cnt decrements; when cnt==1 on that edge, next state is DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency: done is high in the cycle after edge k+amt (amt=0: the cycle after edge k). Start-to-start throughput is amt+2 cycles.
- start while busy is ignored. mode, amt and din may change freely while busy.
- dout and sout hold their values in IDLE until the next accepted start.
- Modes, per step (W=WIDTH):
  - 000 SLL: dout<={dout[W-2:0],0}; sout=dout[W-1]
  - 001 SRL: {0,dout[W-1:1]}; sout=dout[0]
  - 010 SRA: {dout[W-1],dout[W-1:1]}; sout=dout[0]
  - 011 ROL: {dout[W-2:0],dout[W-1]}; sout=dout[W-1]
  - 100 ROR: {dout[0],dout[W-1:1]}; sout=dout[0]
  - 101 SIL: {dout[W-2:0],sin}; sout=dout[W-1]
  - 110 SIR: {sin,dout[W-1:1]}; sout=dout[0]
  - 111 reserved: dout and sout hold, cnt still counts, done timing unchanged
- Amounts >= WIDTH are stepped literally, with no modulo reduction:
  - SLL/SRL end at 0.
  - SRA ends at all-sign bits.
  - Rotates wrap (amt=W returns the operand).
- amt=0: no step; sout is unchanged from its previous value; dout=din.

Test Plan:
- WIDTH=4. Reset, then start with din=0001, mode=000, amt=2 -> busy 2+1 cycles, done pulses 1 cycle after edge k+2, dout=0100, sout=0, busy=0 the following cycle.
- din=1000, mode=010, amt=3 -> dout=1111, sout=0. Repeat with mode=001 -> dout=0001, sout=0.
- din=1001, mode=011, amt=1 -> dout=0011, sout=1. Then din=0010, mode=100, amt=5 -> dout=0001, sout=0 (wrap past WIDTH). Then din=0110, mode=011, amt=4 -> dout=0110.
- din=0000, mode=101, amt=4 with sin=1,0,1,1 on successive SHIFT cycles -> dout=1011. Then mode=110 with the same sin sequence -> dout=1101.
- amt=0, din=1010 -> done 1 cycle after start, dout=1010, busy high for exactly 1 cycle. A start pulse held high throughout busy/DONE is ignored; the next start is taken only after returning to IDLE.
- Start din=1111, mode=000, amt=7; assert rst asynchronously mid-SHIFT (between edges) -> dout=0, busy=0, done=0 immediately, no done pulse. After release, a new start operates normally.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: a captured operand is moved one bit per clock, and a
// start/busy/done handshake brackets each operation.
module shift_unit_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             sout_q, sout_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;

    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // Single 1-bit step of the latched operation. Mode 111 holds both dout and sout.
    always_comb begin
        step_val = dout_q;
        step_out = sout_q;
        case (mode_q)
            3'b000: begin step_val = {dout_q[WIDTH-2:0], 1'b0};          step_out = dout_q[WIDTH-1]; end
            3'b001: begin step_val = {1'b0, dout_q[WIDTH-1:1]};          step_out = dout_q[0];       end
            3'b010: begin step_val = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]}; step_out = dout_q[0];     end
            3'b011: begin step_val = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]}; step_out = dout_q[WIDTH-1]; end
            3'b100: begin step_val = {dout_q[0], dout_q[WIDTH-1:1]};     step_out = dout_q[0];       end
            3'b101: begin step_val = {dout_q[WIDTH-2:0], sin};           step_out = dout_q[WIDTH-1]; end
            3'b110: begin step_val = {sin, dout_q[WIDTH-1:1]};           step_out = dout_q[0];       end
            default: begin step_val = dout_q;                            step_out = sout_q;          end
        endcase
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dout_d  = din;
                    cnt_d   = amt;
                    mode_d  = mode;
                    state_d = (amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                dout_d = step_val;
                sout_d = step_out;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dout_q  <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign dout = dout_q;
    assign sout = sout_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed cases plus random operations scored against an
// arithmetic reference model.
module tb_shift_unit_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic          sin;
    logic [W-1:0]  dout;
    logic          sout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic exp_sout;

    shift_unit_seq #(.WIDTH(W), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mode (mode),
        .amt  (amt),
        .din  (din),
        .sin  (sin),
        .dout (dout),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: n single-bit steps in plain arithmetic; pat[i] is the fill bit of step i.
    task automatic ref_model(input logic [W-1:0] d, input logic [2:0] m, input int n,
                             input logic [7:0] pat, output logic [W-1:0] r, inout logic s);
        logic [W-1:0] v;
        v = d;
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd0: begin s = v[W-1]; v = v << 1; end
                3'd1: begin s = v[0];   v = v >> 1; end
                3'd2: begin s = v[0];   v = $signed(v) >>> 1; end
                3'd3: begin s = v[W-1]; v = (v << 1) | (v >> (W-1)); end
                3'd4: begin s = v[0];   v = (v >> 1) | (v << (W-1)); end
                3'd5: begin s = v[W-1]; v = (v << 1) | W'(pat[i]); end
                3'd6: begin s = v[0];   v = (v >> 1) | (W'(pat[i]) << (W-1)); end
                default: ;
            endcase
        end
        r = v;
    endtask

    task automatic do_op(input logic [W-1:0] d, input logic [2:0] m, input logic [AW-1:0] a,
                         input logic [7:0] pat, input bit hold,
                         input bit chk_d, input logic [W-1:0] ed,
                         input bit chk_s, input logic es);
        logic [W-1:0] md;
        logic         ms;
        int           c;
        bit           seen;
        ms = exp_sout;
        ref_model(d, m, int'(a), pat, md, ms);
        @(negedge clk);
        start = 1'b1; din = d; mode = m; amt = a; sin = pat[0];
        seen = 0;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (!hold) start = 1'b0;
            sin  = (c - 1 < 8) ? pat[c-1] : 1'b0;
            din  = W'($urandom);
            mode = 3'($urandom);
            amt  = AW'($urandom);
            if (done) begin
                seen = 1;
                check("latency", 32'(c), 32'(a) + 32'd1);
                check("busy_at_done", 32'(busy), 32'd1);
                check("dout", 32'(dout), 32'(md));
                check("sout", 32'(sout), 32'(ms));
            end else begin
                check("busy_during", 32'(busy), 32'd1);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
        check("dout_hold", 32'(dout), 32'(md));
        exp_sout = ms;
        if (chk_d) check("spec_dout", 32'(dout), 32'(ed));
        if (chk_s) check("spec_sout", 32'(sout), 32'(es));
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; mode = '0; amt = '0; din = '0; sin = 1'b0;
        exp_sout = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(4'b0001, 3'b000, 3'd2, 8'h00, 0, 1, 4'b0100, 1, 1'b0);
        do_op(4'b1000, 3'b010, 3'd3, 8'h00, 0, 1, 4'b1111, 1, 1'b0);
        do_op(4'b1000, 3'b001, 3'd3, 8'h00, 0, 1, 4'b0001, 1, 1'b0);
        do_op(4'b1001, 3'b011, 3'd1, 8'h00, 0, 1, 4'b0011, 1, 1'b1);
        do_op(4'b0010, 3'b100, 3'd5, 8'h00, 0, 1, 4'b0001, 1, 1'b0);
        do_op(4'b0110, 3'b011, 3'd4, 8'h00, 0, 1, 4'b0110, 0, 1'b0);
        do_op(4'b0000, 3'b101, 3'd4, 8'b1101, 0, 1, 4'b1011, 0, 1'b0);
        do_op(4'b0000, 3'b110, 3'd4, 8'b1101, 0, 1, 4'b1101, 0, 1'b0);
        do_op(4'b1010, 3'b000, 3'd0, 8'h00, 1, 1, 4'b1010, 0, 1'b0);
        do_op(4'b0101, 3'b100, 3'd3, 8'h00, 1, 1, 4'b1010, 0, 1'b0);
        do_op(4'b1100, 3'b111, 3'd6, 8'h00, 0, 1, 4'b1100, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), 3'($urandom), AW'($urandom), 8'($urandom),
                  bit'($urandom_range(0, 1)), 0, '0, 0, 1'b0);
        end

        // Asynchronous reset between edges must clear everything without a done pulse.
        @(negedge clk);
        start = 1'b1; din = 4'b1111; mode = 3'b000; amt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_sout", 32'(sout), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_sout = 1'b0;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);
        do_op(4'b0011, 3'b000, 3'd1, 8'h00, 0, 1, 4'b0110, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
